// File: rtl/user_pkg.sv
// Shared definitions for the user-domain timer: address window, register
// word offsets, CTRL bit layout and byte-enable helpers.
package user_pkg;

    localparam logic [31:0] UserTimerAddrOffset = 32'h2000_1000;
    localparam logic [31:0] UserTimerAddrRange  = 32'h0000_1000;

    // Per-channel register selector (address bits [3:2])
    localparam logic [1:0] RegCtrl     = 2'd0;
    localparam logic [1:0] RegPrescale = 2'd1;
    localparam logic [1:0] RegCount    = 2'd2;
    localparam logic [1:0] RegCmp      = 2'd3;

    // Global STATUS word (address bits [6:2] of 0x7C)
    localparam logic [4:0] WordStatus  = 5'd31;

    // CTRL bit indices
    localparam int unsigned CtrlEnBit     = 0;
    localparam int unsigned CtrlReloadBit = 1;
    localparam int unsigned CtrlIrqEnBit  = 2;
    localparam int unsigned CtrlChainBit  = 3;

    typedef struct packed {
        logic chain;
        logic irq_en;
        logic reload;
        logic en;
    } user_timer_ctrl_t;

    // Expand the 4 byte enables into a 32-bit lane mask
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/user_timer_channel.sv
// One timer channel: prescaler, up-counter and compare-match detection.
// The match pulse is combinational so a following channel can chain on it.
module user_timer_channel #(
    parameter int CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_en,
    input  logic                i_chain,
    input  logic                i_tick_in,
    input  logic [CntWidth-1:0] i_prescale,
    input  logic [CntWidth-1:0] i_cmp,
    input  logic                i_cnt_we,
    input  logic [CntWidth-1:0] i_cnt_wdata,
    input  logic                i_pre_we,
    output logic [CntWidth-1:0] o_count,
    output logic                o_match
);

    logic [CntWidth-1:0] r_pre;
    logic [CntWidth-1:0] r_count;
    logic                w_tick;
    logic                w_hit;

    // Tick source selection and match detection; software writes cancel the tick
    always_comb begin
        w_tick = 1'b0;
        if (!i_en) begin
            w_tick = 1'b0;
        end else if (i_chain) begin
            w_tick = i_tick_in;
        end else begin
            w_tick = (r_pre == i_prescale);
        end
        w_hit   = w_tick && (r_count == i_cmp);
        o_match = w_hit && !i_cnt_we && !i_pre_we;
    end

    // Prescaler: counts up to PRESCALE then restarts; held at 0 when idle or chained
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pre <= '0;
        end else if (!i_en || i_chain) begin
            r_pre <= '0;
        end else if (r_pre == i_prescale) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + CntWidth'(1);
        end
    end

    // Counter: software write wins, otherwise advance or restart on each tick
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (i_cnt_we) begin
            r_count <= i_cnt_wdata;
        end else if (w_tick && !i_pre_we) begin
            r_count <= w_hit ? '0 : r_count + CntWidth'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/user_timer_multi.sv
// Multi-channel user timer with an OBI register interface.
// Optional macro USER_TIMER_CHAIN_EN: lets channel c>0 tick on channel c-1's
// match instead of its own prescaler; without it the CHAIN bit reads as 0.
module user_timer_multi
    import user_pkg::*;
#(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 32,
    parameter int IdWidth     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   obi_req_i,
    output logic                   obi_gnt_o,
    input  logic [31:0]            obi_addr_i,
    input  logic                   obi_we_i,
    input  logic [3:0]             obi_be_i,
    input  logic [31:0]            obi_wdata_i,
    input  logic [IdWidth-1:0]     obi_aid_i,
    output logic                   obi_rvalid_o,
    output logic [31:0]            obi_rdata_o,
    output logic [IdWidth-1:0]     obi_rid_o,
    output logic                   obi_err_o,
    output logic [NumChannels-1:0] irq_o
);

`ifdef USER_TIMER_CHAIN_EN
    localparam logic [3:0] CtrlMask = 4'hF;
`else
    localparam logic [3:0] CtrlMask = 4'h7;
`endif
    localparam logic [3:0] NumCh = 4'(NumChannels);

    user_timer_ctrl_t    r_ctrl     [NumChannels];
    logic [CntWidth-1:0] r_prescale [NumChannels];
    logic [CntWidth-1:0] r_cmp      [NumChannels];
    logic [CntWidth-1:0] w_count    [NumChannels];
    logic [NumChannels-1:0] r_match, w_match, w_tick_in, w_chain, w_clr;
    logic [NumChannels-1:0] w_wr_ctrl, w_wr_pre, w_wr_cnt, w_wr_cmp;

    logic                r_rvalid, r_err;
    logic [31:0]         r_rdata;
    logic [IdWidth-1:0]  r_rid;

    logic [2:0]  w_chan;
    logic [1:0]  w_reg;
    logic        w_is_status, w_valid, w_wr, w_sel;
    logic [31:0] w_rd_val, w_ch_val, w_wmask, w_wval;
    logic        w_unused;

    assign w_unused = ^{obi_addr_i[31:7], obi_addr_i[1:0]};

    // Address decode, read mux, byte-merged write value and write strobes
    always_comb begin
        w_chan      = obi_addr_i[6:4];
        w_reg       = obi_addr_i[3:2];
        w_is_status = (obi_addr_i[6:2] == WordStatus);
        w_valid     = w_is_status || ({1'b0, w_chan} < NumCh);
        w_wr        = obi_req_i && obi_we_i && w_valid;
        w_rd_val    = w_is_status ? 32'(r_match) : 32'd0;
        w_ch_val    = 32'd0;
        w_sel       = 1'b0;
        w_wr_ctrl   = '0;
        w_wr_pre    = '0;
        w_wr_cnt    = '0;
        w_wr_cmp    = '0;
        for (int c = 0; c < NumChannels; c++) begin
            w_sel = !w_is_status && (w_chan == 3'(c));
            case (w_reg)
                RegCtrl:     w_ch_val = 32'(r_ctrl[c]);
                RegPrescale: w_ch_val = 32'(r_prescale[c]);
                RegCount:    w_ch_val = 32'(w_count[c]);
                RegCmp:      w_ch_val = 32'(r_cmp[c]);
                default:     w_ch_val = 32'd0;
            endcase
            w_rd_val     = w_rd_val | ({32{w_sel}} & w_ch_val);
            w_wr_ctrl[c] = w_wr && w_sel && (w_reg == RegCtrl);
            w_wr_pre[c]  = w_wr && w_sel && (w_reg == RegPrescale);
            w_wr_cnt[c]  = w_wr && w_sel && (w_reg == RegCount);
            w_wr_cmp[c]  = w_wr && w_sel && (w_reg == RegCmp);
        end
        w_wmask = be_mask(obi_be_i);
        w_wval  = (w_rd_val & ~w_wmask) | (obi_wdata_i & w_wmask);
        w_clr   = (w_wr && w_is_status) ? NumChannels'(obi_wdata_i & w_wmask) : '0;
    end

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        if (g == 0) begin : g_first
            assign w_tick_in[g] = 1'b0;
            assign w_chain[g]   = 1'b0;
        end else begin : g_rest
            assign w_tick_in[g] = w_match[g-1];
`ifdef USER_TIMER_CHAIN_EN
            assign w_chain[g]   = r_ctrl[g].chain;
`else
            assign w_chain[g]   = 1'b0;
`endif
        end

        user_timer_channel #(
            .CntWidth (CntWidth)
        ) u_channel (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .i_en        (r_ctrl[g].en),
            .i_chain     (w_chain[g]),
            .i_tick_in   (w_tick_in[g]),
            .i_prescale  (r_prescale[g]),
            .i_cmp       (r_cmp[g]),
            .i_cnt_we    (w_wr_cnt[g]),
            .i_cnt_wdata (CntWidth'(w_wval)),
            .i_pre_we    (w_wr_pre[g]),
            .o_count     (w_count[g]),
            .o_match     (w_match[g])
        );

        assign irq_o[g] = r_match[g] & r_ctrl[g].irq_en;
    end

    // Register file: CTRL/PRESCALE/CMP writes, one-shot EN clear, sticky MATCH (set wins)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumChannels; c++) begin
                r_ctrl[c]     <= '0;
                r_prescale[c] <= '0;
                r_cmp[c]      <= '0;
            end
            r_match <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (w_wr_ctrl[c]) begin
                    r_ctrl[c] <= user_timer_ctrl_t'(w_wval[3:0] & CtrlMask);
                end else if (w_match[c] && !r_ctrl[c].reload) begin
                    r_ctrl[c].en <= 1'b0;
                end
                if (w_wr_pre[c]) begin
                    r_prescale[c] <= CntWidth'(w_wval);
                end
                if (w_wr_cmp[c]) begin
                    r_cmp[c] <= CntWidth'(w_wval);
                end
            end
            r_match <= (r_match & ~w_clr) | w_match;
        end
    end

    // Response channel: one cycle after acceptance, errors return zero data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_rid    <= '0;
        end else if (obi_req_i) begin
            r_rvalid <= 1'b1;
            r_err    <= !w_valid;
            r_rdata  <= (w_valid && !obi_we_i) ? w_rd_val : 32'd0;
            r_rid    <= obi_aid_i;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_rid    <= r_rid;
        end
    end

    assign obi_gnt_o    = obi_req_i;
    assign obi_rvalid_o = r_rvalid;
    assign obi_err_o    = r_err;
    assign obi_rdata_o  = r_rdata;
    assign obi_rid_o    = r_rid;

endmodule

// File: tb/tb_user_timer_multi.sv
// Directed testbench for user_timer_multi with a response scoreboard.
module tb_user_timer_multi;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = 32'd0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = 4'h0;
    logic [31:0] obi_wdata_i = 32'd0;
    logic [0:0]  obi_aid_i = 1'b0;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic [0:0]  obi_rid_o;
    logic        obi_err_o;
    logic [1:0]  irq_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    logic [0:0] next_aid = 1'b0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [0:0]  rid;
    } exp_t;
    exp_t sb[$];

    user_timer_multi #(.NumChannels(2), .CntWidth(32), .IdWidth(1)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_aid_i    (obi_aid_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .obi_rid_o    (obi_rid_o),
        .obi_err_o    (obi_err_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One OBI transfer: drive at a negedge, accepted at the next posedge,
    // response checked at the following negedge against the scoreboard.
    task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        exp_t e;
        obi_req_i   = 1'b1;
        obi_addr_i  = addr;
        obi_we_i    = we;
        obi_wdata_i = wdata;
        obi_be_i    = be;
        obi_aid_i   = next_aid;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.rid   = next_aid;
        sb.push_back(e);
        next_aid = ~next_aid;
        chk({tag, ".gnt"}, {31'd0, obi_gnt_o}, 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        obi_req_i = 1'b0;
        obi_we_i  = 1'b0;
        chk({tag, ".rvalid"}, {31'd0, obi_rvalid_o}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".rdata"}, obi_rdata_o, e.rdata);
            chk({tag, ".err"}, {31'd0, obi_err_o}, {31'd0, e.err});
            chk({tag, ".rid"}, {31'd0, obi_rid_o}, {31'd0, e.rid});
        end else begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
        access(addr, 1'b1, data, 4'hF, 32'd0, 1'b0, tag);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        access(addr, 1'b0, 32'd0, 4'hF, exp, 1'b0, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] exp_c1 [7];
        logic [31:0] exp_ctrl;
        exp_c1 = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};

        // Reset state
        idle(3);
        rst_i = 1'b0;
        idle(1);
        chk("rst.rvalid", {31'd0, obi_rvalid_o}, 32'd0);
        chk("rst.irq", {30'd0, irq_o}, 32'd0);
        chk("rst.err", {31'd0, obi_err_o}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd(32'(a * 4), 32'd0, $sformatf("rst.reg%0d", a));
        end
        rd(32'h7C, 32'd0, "rst.status");
        idle(1);
        chk("idle.rvalid", {31'd0, obi_rvalid_o}, 32'd0);

        // Ch0 periodic: PRESCALE=0, CMP=3, EN|RELOAD|IRQ_EN
        wr(32'h04, 32'd0, "c0.pre");
        wr(32'h0C, 32'd3, "c0.cmp");
        wr(32'h00, 32'h7, "c0.ctrl");
        rd(32'h08, 32'd0, "c0.cnt0");
        rd(32'h08, 32'd1, "c0.cnt1");
        rd(32'h08, 32'd2, "c0.cnt2");
        chk("c0.irq_low", {30'd0, irq_o}, 32'd0);
        rd(32'h08, 32'd3, "c0.cnt3");
        chk("c0.irq_high", {30'd0, irq_o}, 32'd1);
        rd(32'h08, 32'd0, "c0.cnt_wrap");
        rd(32'h7C, 32'd1, "c0.status");
        wr(32'h00, 32'd0, "c0.disable");
        wr(32'h7C, 32'd1, "c0.w1c");
        chk("c0.irq_cleared", {30'd0, irq_o}, 32'd0);
        rd(32'h08, 32'd3, "c0.cnt_frozen");
        rd(32'h7C, 32'd0, "c0.status_clr");

        // Ch1 one-shot: PRESCALE=2, CMP=1, EN only
        wr(32'h14, 32'd2, "c1.pre");
        wr(32'h1C, 32'd1, "c1.cmp");
        wr(32'h10, 32'd1, "c1.ctrl");
        for (int i = 0; i < 7; i++) begin
            rd(32'h18, exp_c1[i], $sformatf("c1.cnt%0d", i));
        end
        rd(32'h10, 32'd0, "c1.en_cleared");
        rd(32'h7C, 32'd2, "c1.status");
        chk("c1.irq_masked", {30'd0, irq_o}, 32'd0);
        idle(4);
        rd(32'h18, 32'd0, "c1.cnt_stays");
        wr(32'h7C, 32'd2, "c1.w1c");
        rd(32'h7C, 32'd0, "c1.status_clr");

        // Byte enables
        access(32'h04, 1'b1, 32'hAABB_CCDD, 4'b0001, 32'd0, 1'b0, "be.wr0");
        rd(32'h04, 32'h0000_00DD, "be.rd0");
        access(32'h04, 1'b1, 32'h1122_3344, 4'b0100, 32'd0, 1'b0, "be.wr2");
        rd(32'h04, 32'h0022_00DD, "be.rd2");
        wr(32'h04, 32'd0, "be.restore");

        // Error responses without side effects
        access(32'h20, 1'b0, 32'd0, 4'hF, 32'd0, 1'b1, "err.rd20");
        access(32'h70, 1'b0, 32'd0, 4'hF, 32'd0, 1'b1, "err.rd70");
        access(32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, "err.wr20");
        access(32'h74, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, "err.wr74");
        rd(32'h00, 32'd0, "err.ctrl0");
        rd(32'h0C, 32'd3, "err.cmp0");
        rd(32'h7C, 32'd0, "err.status");

        // Match at all-ones with reload
        wr(32'h0C, 32'hFFFF_FFFF, "wrap.cmp");
        wr(32'h08, 32'hFFFF_FFFE, "wrap.cnt");
        wr(32'h00, 32'h3, "wrap.ctrl");
        rd(32'h08, 32'hFFFF_FFFE, "wrap.cnt_fe");
        rd(32'h08, 32'hFFFF_FFFF, "wrap.cnt_ff");
        rd(32'h08, 32'd0, "wrap.cnt_0");
        rd(32'h7C, 32'd1, "wrap.status");
        wr(32'h00, 32'd0, "wrap.disable");
        wr(32'h7C, 32'd1, "wrap.w1c");

        // Wrap without match
        wr(32'h0C, 32'd5, "nom.cmp");
        wr(32'h08, 32'hFFFF_FFFF, "nom.cnt");
        wr(32'h00, 32'h1, "nom.ctrl");
        rd(32'h08, 32'hFFFF_FFFF, "nom.cnt_ff");
        rd(32'h08, 32'd0, "nom.cnt_0");
        rd(32'h08, 32'd1, "nom.cnt_1");
        wr(32'h00, 32'd0, "nom.disable");
        rd(32'h7C, 32'd0, "nom.status");

        // COUNT write coincident with a tick
        wr(32'h0C, 32'd100, "cw.cmp");
        wr(32'h08, 32'd0, "cw.cnt");
        wr(32'h00, 32'h1, "cw.ctrl");
        rd(32'h08, 32'd0, "cw.cnt_a");
        wr(32'h08, 32'h40, "cw.wr");
        rd(32'h08, 32'h40, "cw.held");
        rd(32'h08, 32'h41, "cw.next");
        wr(32'h00, 32'd0, "cw.disable");

`ifdef USER_TIMER_CHAIN_EN
        // Chained channel 1 counts channel 0 matches
        wr(32'h1C, 32'd2, "ch.cmp1");
        wr(32'h10, 32'hB, "ch.ctrl1");
        wr(32'h0C, 32'd1, "ch.cmp0");
        wr(32'h08, 32'd0, "ch.cnt0");
        wr(32'h00, 32'h3, "ch.ctrl0");
        idle(5);
        rd(32'h7C, 32'd1, "ch.status_before");
        rd(32'h7C, 32'd3, "ch.status_after");
        wr(32'h00, 32'd0, "ch.dis0");
        wr(32'h10, 32'd0, "ch.dis1");
        wr(32'h7C, 32'd3, "ch.w1c");
        exp_ctrl = 32'hF;
`else
        exp_ctrl = 32'h7;
`endif

        // CHAIN bit visibility
        wr(32'h10, 32'hF, "chain.wr");
        rd(32'h10, exp_ctrl, "chain.rd");

        // Reset during an accepted request drops the response
        obi_req_i  = 1'b1;
        obi_addr_i = 32'h10;
        obi_we_i   = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        obi_req_i = 1'b0;
        chk("rstmid.rvalid", {31'd0, obi_rvalid_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(1);
        chk("rstmid.rvalid2", {31'd0, obi_rvalid_o}, 32'd0);
        rd(32'h10, 32'd0, "rstmid.ctrl1");
        rd(32'h1C, 32'd0, "rstmid.cmp1");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
